// File: rtl/mul_pkg.sv
// Shared constants and types for the shift-add multiplier: operand width,
// counter width, controller state encoding and the control-output bundle.
package mul_pkg;

    localparam int N  = 32;
    localparam int CW = $clog2(N) + 1;
    localparam int SW = 3;

    typedef enum logic [SW-1:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_TEST  = 3'd2,
        S_ADD   = 3'd3,
        S_SHIFT = 3'd4,
        S_DONE  = 3'd5
    } state_e;

    typedef struct packed {
        logic ld_operands;
        logic clr_product;
        logic add_enable;
        logic shift_enable;
        logic cnt_load;
        logic cnt_dec;
        logic sel_add_src;
        logic busy;
        logic done;
    } ctrl_t;

    // Moore decode; ADD and SHIFT are separate states so the product and
    // shift registers never update in the same cycle.
    function automatic ctrl_t decode_ctrl(input state_e s);
        ctrl_t c;
        c = '0;
        c.busy = (s != S_IDLE);
        case (s)
            S_LOAD: begin
                c.ld_operands = 1'b1;
                c.clr_product = 1'b1;
                c.cnt_load    = 1'b1;
            end
            S_ADD:   c.add_enable = 1'b1;
            S_SHIFT: begin
                c.shift_enable = 1'b1;
                c.cnt_dec      = 1'b1;
            end
            S_DONE:  c.done = 1'b1;
            default: ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/mul_controller.sv
// Sequencing FSM for the shift-add multiplier datapath. Outputs are registered
// and decoded from the next state, so they always reflect the current state.
module mul_controller
    import mul_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    input  logic cnt_zero,
    input  logic lsb_is_one,
    output logic ld_operands,
    output logic clr_product,
    output logic add_enable,
    output logic shift_enable,
    output logic cnt_load,
    output logic cnt_dec,
    output logic sel_add_src,
    output logic busy,
    output logic done
);

    state_e state_q, state_d;
    ctrl_t  ctrl_q,  ctrl_d;

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  state_d = S_TEST;
            S_TEST: begin
                if (cnt_zero)        state_d = S_DONE;
                else if (lsb_is_one) state_d = S_ADD;
                else                 state_d = S_SHIFT;
            end
            S_ADD:   state_d = S_SHIFT;
            S_SHIFT: state_d = S_TEST;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Abort wins over every transition; datapath contents are left as-is.
        if (abort && (state_q != S_IDLE)) state_d = S_IDLE;
        ctrl_d = decode_ctrl(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ctrl_q  <= '0;
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    assign ld_operands  = ctrl_q.ld_operands;
    assign clr_product  = ctrl_q.clr_product;
    assign add_enable   = ctrl_q.add_enable;
    assign shift_enable = ctrl_q.shift_enable;
    assign cnt_load     = ctrl_q.cnt_load;
    assign cnt_dec      = ctrl_q.cnt_dec;
    assign sel_add_src  = ctrl_q.sel_add_src;
    assign busy         = ctrl_q.busy;
    assign done         = ctrl_q.done;

endmodule

// File: doc/mul_controller.md
# mul_controller

Sequencing FSM for the shift-add multiplier datapath. It accepts a start request, then drives the datapath's load, clear, add, shift and counter controls one step per cycle. Its decisions use the datapath status flags `cnt_zero` and `lsb_is_one`. It reports busy/done to the requester and sits between the requesting logic and the datapath inside the multiplier top level.

## Interface
- `N`, 32, operand width; sets the iteration count loaded into the datapath counter (counter init fixed at N).
- `clk` input 1, clock; all state changes on rising edge.
- `rst` input 1, synchronous, active-high reset.
- `start` input 1, request a multiply; sampled only in IDLE.
- `abort` input 1, cancel the operation in progress and return to IDLE.
- `cnt_zero` input 1, datapath counter equals zero.
- `lsb_is_one` input 1, current multiplier LSB.
- `ld_operands` output 1, load multiplicand/multiplier into the datapath.
- `clr_product` output 1, clear the product accumulator.
- `add_enable` output 1, accumulate the adder result.
- `shift_enable` output 1, shift multiplicand left and multiplier right.
- `cnt_load` output 1, load the counter with N.
- `cnt_dec` output 1, decrement the counter.
- `sel_add_src` output 1, adder source select; tied 0 (multiplicand register).
- `busy` output 1, high in every state except IDLE.
- `done` output 1, one-cycle pulse; product is valid.

## Operation
- States: IDLE, LOAD, TEST, ADD, SHIFT, DONE.
- All control outputs are Moore (decoded from state only) and are 0 unless listed below.
- IDLE
  - `start`=1 → LOAD; otherwise stay in IDLE.
- LOAD
  - Outputs: `ld_operands`=1, `clr_product`=1, `cnt_load`=1.
  - → TEST.
- TEST
  - No outputs asserted.
  - `cnt_zero`=1 → DONE.
  - Else `lsb_is_one`=1 → ADD.
  - Else → SHIFT.
- ADD
  - Outputs: `add_enable`=1.
  - → SHIFT.
- SHIFT
  - Outputs: `shift_enable`=1, `cnt_dec`=1.
  - → TEST.
- DONE
  - Outputs: `done`=1.
  - → IDLE. A `start` seen in DONE is ignored.
- ADD and SHIFT are never asserted in the same cycle, so the product register and the shift registers never update together.
- `start` while busy is ignored; it is not queued.
- `abort`=1 in any state other than IDLE → IDLE on the next edge.
  - No `done` pulse is produced.
  - Datapath contents are left as-is (undefined result).
- `abort` has priority over all other transitions; `rst` has priority over `abort`.
- Reset mid-operation → IDLE on the next edge; all outputs 0.

## Timing
- Reset values: state IDLE; every output 0, including `busy` and `done`.
- Cycle numbering: cycle 1 is the cycle after the edge that samples `start`=1 in IDLE.
  - LOAD occupies cycle 1.
  - Iterations occupy cycles 2..65+k, where k = popcount(multiplier).
  - Final TEST (`cnt_zero`=1) occupies cycle 66+k.
  - DONE occupies cycle 67+k.
- Latency is 67 cycles minimum (multiplier 0) and 99 maximum (0xFFFFFFFF).
- `busy` is high from cycle 1 through DONE inclusive, and low the cycle after.
- The product output is valid in the DONE cycle and holds until the next LOAD.
- Back-to-back: `start` held high through DONE is accepted in the following IDLE cycle, giving a one-cycle idle gap.
- The counter reaches 0 after exactly N SHIFT states; `cnt_zero` is observed only in TEST.

## Structure
- Shared package `mul_pkg`:
  - State encoding localparams: S_IDLE=0, S_LOAD=1, S_TEST=2, S_ADD=3, S_SHIFT=4, S_DONE=5, in a 3-bit state width.
  - Counter width constant CW=6 (derived as clog2(N)+1).
- Single flat module with no sub-module.
- Integration wrapper `mul_top` instantiates `mul_controller` and the datapath. It is the verification DUT for the end-to-end tests.

## Test plan
- Reset held for 3 cycles, then released with `start`=0 → all outputs 0 and `busy`=0 indefinitely.
- 7 × 5 (k=2) → `done` pulse in cycle 69, product 35, exactly 2 `add_enable` cycles and 32 `shift_enable` cycles.
- 0x12345678 × 0 → `done` in cycle 67, product 0, `add_enable` never asserted.
- 0xFFFFFFFF × 0xFFFFFFFF → `done` in cycle 99, product 0xFFFFFFFE00000001.
- `start` pulsed at cycle 10 of an operation → ignored; a single `done` pulse, and the result equals the first operands' product.
- `abort` at cycle 20 → IDLE next cycle, `busy`=0, no `done`. A new 3×3 then completes with product 9 in cycle 69.
